eth_tx_arbiter: RTL and testbench

- Shares the single RMII transmit serializer between N_SRC frame sources, for example an ARP responder and a UDP sender.
- Sits between the source byte streams and the rmii TX serializer that drives tx_en and the TX data pins.
- Grants whole frames using round-robin arbitration and enforces the inter-frame gap.
- Aborts frames that underrun or exceed the maximum frame length.

---
 rtl/eth_types_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/eth_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_eth_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_types_pkg.sv
// Shared Ethernet constants and types for the RMII transmit path.
package eth_types_pkg;

  localparam int ETH_IFG_CLKS        = 48;
  localparam int ETH_MAX_FRAME_BYTES = 1514;

  typedef enum logic [1:0] {TXA_IDLE, TXA_XFER, TXA_GAP} tx_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: one-hot pick of the first requester
// found scanning upward from ptr+1, wrapping modulo N_SRC.
module rr_arbiter #(
  parameter int N_SRC = 2,
  localparam int PW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [PW-1:0]    idx
);

  logic found;
  int   cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = (int'(ptr) + k) % N_SRC;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin whole-frame arbiter in front of the RMII TX serializer, with
// inter-frame gap enforcement and underrun/oversize aborts.
module eth_tx_arbiter
  import eth_types_pkg::*;
#(
  parameter int N_SRC           = 2,
  parameter int IFG_CLKS        = ETH_IFG_CLKS,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_SRC-1:0]      src_req,
  input  logic [N_SRC-1:0][7:0] src_byte,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC-1:0]      src_last,
  output logic [N_SRC-1:0]      src_ready,
  output logic [N_SRC-1:0]      src_gnt,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  tx_abort,
  output logic                  busy,
  output logic                  err_underrun,
  output logic                  err_oversize
);

  localparam int PW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);
  localparam int GW  = (IFG_CLKS > 1) ? $clog2(IFG_CLKS) : 1;

  localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_FRAME_BYTES - 1);
  localparam logic [BCW-1:0] BYTE_SAT = BCW'(MAX_FRAME_BYTES);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(IFG_CLKS - 1);

  tx_arb_state_t  state;
  logic [PW-1:0]  rr_ptr;
  logic [BCW-1:0] byte_cnt;
  logic [GW-1:0]  gap_cnt;

  logic [N_SRC-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             in_xfer, sel_req, sel_valid, sel_last, accept;

  rr_arbiter #(.N_SRC(N_SRC)) u_rr (
    .req (src_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // rr_ptr always holds the current winner, so it doubles as the mux select.
  always_comb begin
    in_xfer   = (state == TXA_XFER);
    sel_req   = src_req[rr_ptr];
    sel_valid = src_valid[rr_ptr];
    sel_last  = src_last[rr_ptr];
    accept    = in_xfer && tx_ready && sel_valid;
    tx_byte   = in_xfer ? src_byte[rr_ptr] : 8'h00;
    tx_valid  = in_xfer && sel_valid;
    tx_last   = in_xfer && sel_last;
    busy      = (state != TXA_IDLE);
    src_ready = '0;
    if (in_xfer) src_ready[rr_ptr] = tx_ready;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= TXA_IDLE;
      src_gnt      <= '0;
      rr_ptr       <= PW'(N_SRC - 1);
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      tx_abort     <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      tx_abort     <= 1'b0;
      err_underrun <= 1'b0;
      err_oversize <= 1'b0;
      case (state)
        TXA_IDLE: begin
          if (|src_req) begin
            state   <= TXA_XFER;
            src_gnt <= pick_gnt;
            rr_ptr  <= pick_idx;
          end
        end
        TXA_XFER: begin
          // An accepted byte outranks withdrawal: the serializer has already taken it.
          if (accept) begin
            if (sel_last) begin
              state    <= TXA_GAP;
              src_gnt  <= '0;
              gap_cnt  <= GAP_LOAD;
              byte_cnt <= '0;
            end else if (byte_cnt == LAST_CNT) begin
              state        <= TXA_GAP;
              src_gnt      <= '0;
              gap_cnt      <= GAP_LOAD;
              byte_cnt     <= '0;
              tx_abort     <= 1'b1;
              err_oversize <= 1'b1;
            end else if (byte_cnt != BYTE_SAT) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tx_ready && !sel_valid && (byte_cnt != '0)) begin
            state        <= TXA_GAP;
            src_gnt      <= '0;
            gap_cnt      <= GAP_LOAD;
            byte_cnt     <= '0;
            tx_abort     <= 1'b1;
            err_underrun <= 1'b1;
          end else if (!sel_req && (byte_cnt == '0)) begin
            state   <= TXA_IDLE;
            src_gnt <= '0;
          end
        end
        TXA_GAP: begin
          if (gap_cnt == '0) state <= TXA_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= TXA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed testbench for eth_tx_arbiter: behavioural frame sources, a
// serializer that takes a byte every 4th clock, and immediate-assertion checks.
module tb_eth_tx_arbiter;

  logic            clk = 1'b0;
  logic            resetn;
  logic [1:0]      src_req, src_valid, src_last, src_ready, src_gnt;
  logic [1:0][7:0] src_byte;
  logic [7:0]      tx_byte;
  logic            tx_valid, tx_last, tx_ready, tx_abort, busy;
  logic            err_underrun, err_oversize;

  always #10 clk = ~clk;

  eth_tx_arbiter #(
    .N_SRC           (2),
    .IFG_CLKS        (48),
    .MAX_FRAME_BYTES (1514)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .src_req      (src_req),
    .src_byte     (src_byte),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .src_gnt      (src_gnt),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .tx_abort     (tx_abort),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_oversize (err_oversize)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Source model configuration: valid drops once pos reaches stop_at.
  int len[2], stop_at[2], frames_left[2], pos[2];
  bit has_last[2];

  int n_acc[2];
  int n_tx, tx_idx, n_tx_last, last_tx_idx, bad_bytes;
  int n_abort, n_under, n_over, abort_cyc, last_acc_cyc, busy_cycles, ready1_cnt;
  bit chk_bytes;
  int exp_src;
  logic [1:0] prev_gnt;
  logic [1:0] gnt_val_q[$];
  int         gnt_cyc_q[$];
  int         last_cyc_q[$];

  int k, g, g2, ab;

  function automatic logic [7:0] pat(input int s, input int p);
    return 8'((p + s * 128) % 256);
  endfunction

  task automatic clearStats();
    n_acc[0] = 0; n_acc[1] = 0;
    n_tx = 0; tx_idx = 0; n_tx_last = 0; last_tx_idx = 0; bad_bytes = 0;
    n_abort = 0; n_under = 0; n_over = 0; abort_cyc = -1; last_acc_cyc = -1;
    busy_cycles = 0; ready1_cnt = 0;
    gnt_val_q.delete(); gnt_cyc_q.delete(); last_cyc_q.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive inputs at negedge, then observe mid low phase; the accept decided
  // here happens at the following posedge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      tx_ready = (cyc % 4 == 0);
      for (int s = 0; s < 2; s++) begin
        src_req[s]   = (frames_left[s] > 0);
        src_valid[s] = (frames_left[s] > 0) && (pos[s] < stop_at[s]) && (pos[s] < len[s]);
        src_byte[s]  = pat(s, pos[s]);
        src_last[s]  = has_last[s] && (pos[s] == len[s] - 1);
      end
      #5;
      for (int s = 0; s < 2; s++) begin
        if (src_ready[s] && src_valid[s]) begin
          n_acc[s]++;
          last_acc_cyc = cyc;
          if (src_last[s]) begin
            last_cyc_q.push_back(cyc);
            frames_left[s]--;
            pos[s] = 0;
          end else begin
            pos[s]++;
          end
        end
      end
      if (tx_valid && tx_ready) begin
        if (chk_bytes && (tx_byte !== pat(exp_src, tx_idx))) bad_bytes++;
        tx_idx++;
        n_tx++;
        if (tx_last) begin
          n_tx_last++;
          last_tx_idx = n_tx;
        end
      end
      if (tx_abort) begin n_abort++; abort_cyc = cyc; end
      if (err_underrun) n_under++;
      if (err_oversize) n_over++;
      if (busy) busy_cycles++;
      if (src_ready[1]) ready1_cnt++;
      if ((src_gnt !== prev_gnt) && (src_gnt != 2'b00)) begin
        gnt_val_q.push_back(src_gnt);
        gnt_cyc_q.push_back(cyc);
      end
      prev_gnt = src_gnt;
    end
  endtask

  task automatic waitGrant(input logic [1:0] want, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      applyStimulus(1);
      if (src_gnt === want) at = cyc;
    end
  endtask

  task automatic waitAbort(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      applyStimulus(1);
      if (tx_abort === 1'b1) at = cyc;
    end
  endtask

  initial begin
    #(20 * 40000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0; tx_ready = 1'b0;
    src_req = '0; src_valid = '0; src_last = '0; src_byte = '0;
    prev_gnt = '0; chk_bytes = 0; exp_src = 0;
    for (int s = 0; s < 2; s++) begin
      len[s] = 0; stop_at[s] = 0; frames_left[s] = 0; pos[s] = 0; has_last[s] = 0;
    end
    clearStats();

    // Reset values
    applyStimulus(3);
    checkOutput("rst_gnt", 32'(src_gnt), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 0);
    checkOutput("rst_tx_abort", 32'(tx_abort), 0);
    checkOutput("rst_src_ready", 32'(src_ready), 0);
    resetn = 1'b1;
    applyStimulus(2);
    checkOutput("idle_busy", 32'(busy), 0);

    // 1: single 60-byte frame from source 0
    clearStats();
    chk_bytes = 1; exp_src = 0;
    len[0] = 60; has_last[0] = 1; stop_at[0] = 1000; pos[0] = 0; frames_left[0] = 1;
    k = cyc + 1;
    applyStimulus(400);
    checkOutput("t1_gnt_count", gnt_val_q.size(), 1);
    checkOutput("t1_gnt_val", 32'(gnt_val_q[0]), 32'h1);
    checkOutput("t1_gnt_latency", gnt_cyc_q[0] - k, 1);
    checkOutput("t1_tx_bytes", n_tx, 60);
    checkOutput("t1_byte_order_errs", bad_bytes, 0);
    checkOutput("t1_last_position", last_tx_idx, 60);
    checkOutput("t1_last_count", n_tx_last, 1);
    checkOutput("t1_errors", n_abort + n_under + n_over, 0);
    checkOutput("t1_busy_cycles", busy_cycles, last_acc_cyc + 48 - k);
    checkOutput("t1_idle_after", 32'(busy), 0);

    // 2: both sources framing; rr_ptr points at source 0 now, so source 1 leads
    clearStats();
    chk_bytes = 0;
    for (int s = 0; s < 2; s++) begin
      len[s] = 20; has_last[s] = 1; stop_at[s] = 1000; pos[s] = 0; frames_left[s] = 2;
    end
    applyStimulus(700);
    checkOutput("t2_gnt_count", gnt_val_q.size(), 4);
    checkOutput("t2_last_count", last_cyc_q.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t2_gnt_val%0d", i), 32'(gnt_val_q[i]),
                  (i % 2 == 0) ? 32'h2 : 32'h1);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("t2_gap%0d", i), gnt_cyc_q[i] - last_cyc_q[i-1], 50);
    checkOutput("t2_tx_bytes", n_tx, 80);
    checkOutput("t2_errors", n_abort + n_under + n_over, 0);

    // 3: source 0 underruns after 10 bytes, source 1 waiting
    clearStats();
    len[0] = 100; has_last[0] = 1; stop_at[0] = 10; pos[0] = 0; frames_left[0] = 1;
    len[1] = 8;   has_last[1] = 1; stop_at[1] = 1000; pos[1] = 0; frames_left[1] = 0;
    waitGrant(2'b01, 10, g);
    checkOutput("t3_gnt_src0", 32'(src_gnt), 32'h1);
    frames_left[1] = 1;
    waitAbort(200, ab);
    frames_left[0] = 0;
    checkOutput("t3_acc_src0", n_acc[0], 10);
    checkOutput("t3_underrun", n_under, 1);
    checkOutput("t3_oversize", n_over, 0);
    checkOutput("t3_abort_delay", ab - last_acc_cyc, 5);
    waitGrant(2'b10, 60, g);
    checkOutput("t3_regrant_delay", g - ab, 49);
    checkOutput("t3_abort_once", n_abort, 1);
    applyStimulus(100);
    checkOutput("t3_acc_src1", n_acc[1], 8);

    // 4: source 1 streams without last until the oversize abort
    clearStats();
    chk_bytes = 1; exp_src = 1;
    len[1] = 1600; has_last[1] = 0; stop_at[1] = 100000; pos[1] = 0; frames_left[1] = 1;
    waitAbort(7000, ab);
    checkOutput("t4_acc_src1", n_acc[1], 1514);
    checkOutput("t4_tx_bytes", n_tx, 1514);
    checkOutput("t4_byte_errs", bad_bytes, 0);
    checkOutput("t4_oversize", n_over, 1);
    checkOutput("t4_underrun", n_under, 0);
    checkOutput("t4_no_last", n_tx_last, 0);
    ready1_cnt = 0;
    applyStimulus(40);
    checkOutput("t4_ready_off", ready1_cnt, 0);
    checkOutput("t4_abort_once", n_abort, 1);
    frames_left[1] = 0;
    applyStimulus(20);
    checkOutput("t4_idle_after", 32'(busy), 0);

    // 5: source 0 withdraws before its first byte while source 1 requests
    clearStats();
    chk_bytes = 0;
    len[0] = 10; has_last[0] = 1; stop_at[0] = 0; pos[0] = 0; frames_left[0] = 1;
    len[1] = 4;  has_last[1] = 1; stop_at[1] = 1000; pos[1] = 0; frames_left[1] = 0;
    waitGrant(2'b01, 10, g);
    checkOutput("t5_gnt_src0", 32'(src_gnt), 32'h1);
    frames_left[0] = 0; frames_left[1] = 1;
    k = cyc + 1;
    waitGrant(2'b10, 10, g2);
    checkOutput("t5_gnt_src1_delay", g2 - k, 2);
    checkOutput("t5_no_abort", n_abort + n_under + n_over, 0);
    applyStimulus(100);
    checkOutput("t5_acc_src1", n_acc[1], 4);
    checkOutput("t5_last_count", n_tx_last, 1);

    // 6: reset in the middle of a frame
    clearStats();
    len[0] = 100; has_last[0] = 1; stop_at[0] = 1000; pos[0] = 0; frames_left[0] = 1;
    for (int i = 0; i < 400 && n_acc[0] < 30; i++) applyStimulus(1);
    checkOutput("t6_reached_byte30", n_acc[0], 30);
    checkOutput("t6_pre_gnt", 32'(src_gnt), 32'h1);
    checkOutput("t6_pre_busy", 32'(busy), 1);
    resetn = 1'b0;
    #1;
    checkOutput("t6_rst_gnt", 32'(src_gnt), 0);
    checkOutput("t6_rst_tx_valid", 32'(tx_valid), 0);
    checkOutput("t6_rst_busy", 32'(busy), 0);
    checkOutput("t6_rst_src_ready", 32'(src_ready), 0);
    for (int s = 0; s < 2; s++) begin
      len[s] = 5; has_last[s] = 1; stop_at[s] = 1000; pos[s] = 0; frames_left[s] = 1;
    end
    applyStimulus(3);
    clearStats();
    resetn = 1'b1;
    applyStimulus(200);
    checkOutput("t6_gnt_count", gnt_val_q.size(), 2);
    checkOutput("t6_first_gnt", 32'(gnt_val_q[0]), 32'h1);
    checkOutput("t6_second_gnt", 32'(gnt_val_q[1]), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
